// File: rtl/deserializer_1x8_1bit.sv
// Serial-to-parallel collector: gathers 8 accepted 1-bit samples into a word
// and presents it on a valid/ready port until the consumer takes it.
module deserializer_1x8_1bit #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] word,
    output logic       word_valid,
    input  logic       word_ready,
    output logic [2:0] sel
);

    localparam int unsigned WORD_W = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WORD_W-1:0]   next_word;
    logic [SEL_W-1:0]    next_sel;
    logic [SEL_W-1:0]    idx;

    // Handshake flags are pure decodes of the state register.
    assign din_ready  = (state == FILL);
    assign word_valid = (state == HOLD);

    assign idx = LSB_FIRST ? sel : (SEL_W'(WORD_W - 1) - sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            word  <= '0;
            sel   <= '0;
        end else begin
            state <= next_state;
            word  <= next_word;
            sel   <= next_sel;
        end
    end

    // Next-state: clear dominates; sel wraps to 0 only on the 8th accept.
    always_comb begin
        next_state = state;
        next_word  = word;
        next_sel   = sel;
        if (clear) begin
            next_state = FILL;
            next_word  = '0;
            next_sel   = '0;
        end else begin
            case (state)
                FILL: begin
                    if (din_valid) begin
                        next_word[idx] = din;
                        next_sel       = sel + SEL_W'(1);
                        if (sel == SEL_W'(WORD_W - 1)) begin
                            next_state = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (word_ready) begin
                        next_state = FILL;
                        next_word  = '0;
                    end
                end
                default: begin
                    next_state = FILL;
                end
            endcase
        end
    end

endmodule
